// File: rtl/axi_pkg.sv
// Shared AXI-Lite types and constants for the IFU/LSU memory arbiter.
// Bus-width macros are given defaults here when the SoC build does not supply them.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 31:0
`endif
`ifndef YSYX_23060251_AXI_DATA_BUS
`define YSYX_23060251_AXI_DATA_BUS 31:0
`endif
`ifndef YSYX_23060251_AXI_STRB_BUS
`define YSYX_23060251_AXI_STRB_BUS 3:0
`endif

package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  localparam int MST_IFU = 0;
  localparam int MST_LSU = 1;

  localparam logic [4:0] ST_IDLE  = 5'b00001;
  localparam logic [4:0] ST_RD_M0 = 5'b00010;
  localparam logic [4:0] ST_RD_M1 = 5'b00100;
  localparam logic [4:0] ST_WR_M0 = 5'b01000;
  localparam logic [4:0] ST_WR_M1 = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE  = ST_IDLE,
    S_RD_M0 = ST_RD_M0,
    S_RD_M1 = ST_RD_M1,
    S_WR_M0 = ST_WR_M0,
    S_WR_M1 = ST_WR_M1
  } arb_state_e;

endpackage

// File: rtl/axi_lite_arbiter_arb_pick.sv
// Two-way winner select for the memory arbiter, purely combinational.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the LSU wins ties.
module arb_pick
  import axi_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      // last_grant_i holds the index of the previous winner
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else begin
      grant_o = req_i;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    grant_o          = 2'b00;
    grant_o[MST_LSU] = req_i[MST_LSU];
    grant_o[MST_IFU] = req_i[MST_IFU] & ~req_i[MST_LSU];
  end
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-master (IFU/LSU) to one-slave AXI-Lite arbiter, one transaction at a time.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of LSU priority.
module axi_lite_arbiter
  import axi_pkg::*;
#(
  parameter int NUM_MST = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  // master 0 (IFU)
  input  logic                               m0_ar_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS] m0_ar_addr_i,
  output logic                               m0_ar_ready_o,
  output logic                               m0_r_valid_o,
  output logic [`YSYX_23060251_AXI_DATA_BUS] m0_r_data_o,
  output axi_resp_t                          m0_r_resp_o,
  input  logic                               m0_r_ready_i,
  input  logic                               m0_aw_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS] m0_aw_addr_i,
  output logic                               m0_aw_ready_o,
  input  logic                               m0_w_valid_i,
  input  logic [`YSYX_23060251_AXI_DATA_BUS] m0_w_data_i,
  input  logic [`YSYX_23060251_AXI_STRB_BUS] m0_w_strb_i,
  output logic                               m0_w_ready_o,
  output logic                               m0_b_valid_o,
  output axi_resp_t                          m0_b_resp_o,
  input  logic                               m0_b_ready_i,
  // master 1 (LSU)
  input  logic                               m1_ar_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS] m1_ar_addr_i,
  output logic                               m1_ar_ready_o,
  output logic                               m1_r_valid_o,
  output logic [`YSYX_23060251_AXI_DATA_BUS] m1_r_data_o,
  output axi_resp_t                          m1_r_resp_o,
  input  logic                               m1_r_ready_i,
  input  logic                               m1_aw_valid_i,
  input  logic [`YSYX_23060251_AXI_ADDR_BUS] m1_aw_addr_i,
  output logic                               m1_aw_ready_o,
  input  logic                               m1_w_valid_i,
  input  logic [`YSYX_23060251_AXI_DATA_BUS] m1_w_data_i,
  input  logic [`YSYX_23060251_AXI_STRB_BUS] m1_w_strb_i,
  output logic                               m1_w_ready_o,
  output logic                               m1_b_valid_o,
  output axi_resp_t                          m1_b_resp_o,
  input  logic                               m1_b_ready_i,
  // slave
  output logic                               s_ar_valid_o,
  output logic [`YSYX_23060251_AXI_ADDR_BUS] s_ar_addr_o,
  input  logic                               s_ar_ready_i,
  input  logic                               s_r_valid_i,
  input  logic [`YSYX_23060251_AXI_DATA_BUS] s_r_data_i,
  input  axi_resp_t                          s_r_resp_i,
  output logic                               s_r_ready_o,
  output logic                               s_aw_valid_o,
  output logic [`YSYX_23060251_AXI_ADDR_BUS] s_aw_addr_o,
  input  logic                               s_aw_ready_i,
  output logic                               s_w_valid_o,
  output logic [`YSYX_23060251_AXI_DATA_BUS] s_w_data_o,
  output logic [`YSYX_23060251_AXI_STRB_BUS] s_w_strb_o,
  input  logic                               s_w_ready_i,
  input  logic                               s_b_valid_i,
  input  axi_resp_t                          s_b_resp_i,
  output logic                               s_b_ready_o,
  output logic [1:0]                         grant_o
);

  logic [NUM_MST-1:0] ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [NUM_MST-1:0][$bits(s_ar_addr_o)-1:0] ar_addr, aw_addr;
  logic [NUM_MST-1:0][$bits(s_w_data_o)-1:0]  w_data;
  logic [NUM_MST-1:0][$bits(s_w_strb_o)-1:0]  w_strb;

  assign ar_valid = {m1_ar_valid_i, m0_ar_valid_i};
  assign ar_addr  = {m1_ar_addr_i,  m0_ar_addr_i};
  assign r_ready  = {m1_r_ready_i,  m0_r_ready_i};
  assign aw_valid = {m1_aw_valid_i, m0_aw_valid_i};
  assign aw_addr  = {m1_aw_addr_i,  m0_aw_addr_i};
  assign w_valid  = {m1_w_valid_i,  m0_w_valid_i};
  assign w_data   = {m1_w_data_i,   m0_w_data_i};
  assign w_strb   = {m1_w_strb_i,   m0_w_strb_i};
  assign b_ready  = {m1_b_ready_i,  m0_b_ready_i};

  arb_state_e         state_q, state_d;
  logic [NUM_MST-1:0] rd_own, wr_own, req, win;
  logic               pick_last;

  assign rd_own  = {state_q == S_RD_M1, state_q == S_RD_M0};
  assign wr_own  = {state_q == S_WR_M1, state_q == S_WR_M0};
  assign req     = ar_valid | aw_valid;
  assign grant_o = rd_own | wr_own;

  arb_pick u_pick (
    .req_i        (req),
    .last_grant_i (pick_last),
    .grant_o      (win)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && (|win)) last_d = win[MST_LSU];
  end

  // reset to 1 so the first tie after reset goes to the IFU
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  assign pick_last = last_q;
`else
  assign pick_last = 1'b1;
`endif

  // a master raising AR and AW together gets its read first
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win[MST_IFU])      state_d = ar_valid[MST_IFU] ? S_RD_M0 : S_WR_M0;
        else if (win[MST_LSU]) state_d = ar_valid[MST_LSU] ? S_RD_M1 : S_WR_M1;
      end
      S_RD_M0, S_RD_M1: if (s_r_valid_i && s_r_ready_o) state_d = S_IDLE;
      S_WR_M0, S_WR_M1: if (s_b_valid_i && s_b_ready_o) state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // slave side: AND-OR select by owner, so idle drives all zeros
  always_comb begin
    s_ar_valid_o = 1'b0;
    s_ar_addr_o  = '0;
    s_r_ready_o  = 1'b0;
    s_aw_valid_o = 1'b0;
    s_aw_addr_o  = '0;
    s_w_valid_o  = 1'b0;
    s_w_data_o   = '0;
    s_w_strb_o   = '0;
    s_b_ready_o  = 1'b0;
    for (int n = 0; n < NUM_MST; n++) begin
      s_ar_valid_o |= rd_own[n] & ar_valid[n];
      s_ar_addr_o  |= rd_own[n] ? ar_addr[n] : '0;
      s_r_ready_o  |= rd_own[n] & r_ready[n];
      s_aw_valid_o |= wr_own[n] & aw_valid[n];
      s_aw_addr_o  |= wr_own[n] ? aw_addr[n] : '0;
      s_w_valid_o  |= wr_own[n] & w_valid[n];
      s_w_data_o   |= wr_own[n] ? w_data[n] : '0;
      s_w_strb_o   |= wr_own[n] ? w_strb[n] : '0;
      s_b_ready_o  |= wr_own[n] & b_ready[n];
    end
  end

  logic      [NUM_MST-1:0] m_ar_ready, m_r_valid, m_aw_ready, m_w_ready, m_b_valid;
  logic      [NUM_MST-1:0][$bits(s_r_data_i)-1:0] m_r_data;
  axi_resp_t [NUM_MST-1:0] m_r_resp, m_b_resp;

  for (genvar n = 0; n < NUM_MST; n++) begin : g_mst
    assign m_ar_ready[n] = rd_own[n] & s_ar_ready_i;
    assign m_r_valid[n]  = rd_own[n] & s_r_valid_i;
    assign m_r_data[n]   = rd_own[n] ? s_r_data_i : '0;
    assign m_r_resp[n]   = rd_own[n] ? s_r_resp_i : OKAY;
    assign m_aw_ready[n] = wr_own[n] & s_aw_ready_i;
    assign m_w_ready[n]  = wr_own[n] & s_w_ready_i;
    assign m_b_valid[n]  = wr_own[n] & s_b_valid_i;
    assign m_b_resp[n]   = wr_own[n] ? s_b_resp_i : OKAY;
  end

  assign m0_ar_ready_o = m_ar_ready[MST_IFU];
  assign m0_r_valid_o  = m_r_valid[MST_IFU];
  assign m0_r_data_o   = m_r_data[MST_IFU];
  assign m0_r_resp_o   = m_r_resp[MST_IFU];
  assign m0_aw_ready_o = m_aw_ready[MST_IFU];
  assign m0_w_ready_o  = m_w_ready[MST_IFU];
  assign m0_b_valid_o  = m_b_valid[MST_IFU];
  assign m0_b_resp_o   = m_b_resp[MST_IFU];

  assign m1_ar_ready_o = m_ar_ready[MST_LSU];
  assign m1_r_valid_o  = m_r_valid[MST_LSU];
  assign m1_r_data_o   = m_r_data[MST_LSU];
  assign m1_r_resp_o   = m_r_resp[MST_LSU];
  assign m1_aw_ready_o = m_aw_ready[MST_LSU];
  assign m1_w_ready_o  = m_w_ready[MST_LSU];
  assign m1_b_valid_o  = m_b_valid[MST_LSU];
  assign m1_b_resp_o   = m_b_resp[MST_LSU];

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: reads, writes, ties, contention, async reset.
// Tie expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
`ifndef YSYX_23060251_AXI_ADDR_BUS
`define YSYX_23060251_AXI_ADDR_BUS 31:0
`endif
`ifndef YSYX_23060251_AXI_DATA_BUS
`define YSYX_23060251_AXI_DATA_BUS 31:0
`endif
`ifndef YSYX_23060251_AXI_STRB_BUS
`define YSYX_23060251_AXI_STRB_BUS 3:0
`endif

module tb_axi_lite_arbiter;
  import axi_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [1:0]       ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [1:0][31:0] ar_addr, aw_addr, w_data;
  logic [1:0][3:0]  w_strb;
  logic             s_ar_ready_i, s_r_valid_i, s_aw_ready_i, s_w_ready_i, s_b_valid_i;
  logic [31:0]      s_r_data_i;
  axi_resp_t        s_r_resp_i, s_b_resp_i;

  wire [1:0]       o_ar_ready, o_r_valid, o_aw_ready, o_w_ready, o_b_valid;
  wire [1:0][31:0] o_r_data;
  axi_resp_t       o_r_resp0, o_r_resp1, o_b_resp0, o_b_resp1;
  wire             s_ar_valid_o, s_r_ready_o, s_aw_valid_o, s_w_valid_o, s_b_ready_o;
  wire [31:0]      s_ar_addr_o, s_aw_addr_o, s_w_data_o;
  wire [3:0]       s_w_strb_o;
  wire [1:0]       grant_o;

  axi_lite_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_ar_valid_i(ar_valid[0]), .m0_ar_addr_i(ar_addr[0]), .m0_ar_ready_o(o_ar_ready[0]),
    .m0_r_valid_o(o_r_valid[0]), .m0_r_data_o(o_r_data[0]), .m0_r_resp_o(o_r_resp0),
    .m0_r_ready_i(r_ready[0]), .m0_aw_valid_i(aw_valid[0]), .m0_aw_addr_i(aw_addr[0]),
    .m0_aw_ready_o(o_aw_ready[0]), .m0_w_valid_i(w_valid[0]), .m0_w_data_i(w_data[0]),
    .m0_w_strb_i(w_strb[0]), .m0_w_ready_o(o_w_ready[0]), .m0_b_valid_o(o_b_valid[0]),
    .m0_b_resp_o(o_b_resp0), .m0_b_ready_i(b_ready[0]),
    .m1_ar_valid_i(ar_valid[1]), .m1_ar_addr_i(ar_addr[1]), .m1_ar_ready_o(o_ar_ready[1]),
    .m1_r_valid_o(o_r_valid[1]), .m1_r_data_o(o_r_data[1]), .m1_r_resp_o(o_r_resp1),
    .m1_r_ready_i(r_ready[1]), .m1_aw_valid_i(aw_valid[1]), .m1_aw_addr_i(aw_addr[1]),
    .m1_aw_ready_o(o_aw_ready[1]), .m1_w_valid_i(w_valid[1]), .m1_w_data_i(w_data[1]),
    .m1_w_strb_i(w_strb[1]), .m1_w_ready_o(o_w_ready[1]), .m1_b_valid_o(o_b_valid[1]),
    .m1_b_resp_o(o_b_resp1), .m1_b_ready_i(b_ready[1]),
    .s_ar_valid_o(s_ar_valid_o), .s_ar_addr_o(s_ar_addr_o), .s_ar_ready_i(s_ar_ready_i),
    .s_r_valid_i(s_r_valid_i), .s_r_data_i(s_r_data_i), .s_r_resp_i(s_r_resp_i),
    .s_r_ready_o(s_r_ready_o), .s_aw_valid_o(s_aw_valid_o), .s_aw_addr_o(s_aw_addr_o),
    .s_aw_ready_i(s_aw_ready_i), .s_w_valid_o(s_w_valid_o), .s_w_data_o(s_w_data_o),
    .s_w_strb_o(s_w_strb_o), .s_w_ready_i(s_w_ready_i), .s_b_valid_i(s_b_valid_i),
    .s_b_resp_i(s_b_resp_i), .s_b_ready_o(s_b_ready_o), .grant_o(grant_o)
  );

  wire [1:0] o_b_resp_bits [2];
  assign o_b_resp_bits[0] = o_b_resp0;
  assign o_b_resp_bits[1] = o_b_resp1;

  wire m0_any = |{o_ar_ready[0], o_r_valid[0], o_r_data[0], o_r_resp0,
                  o_aw_ready[0], o_w_ready[0], o_b_valid[0], o_b_resp0};
  wire m1_any = |{o_ar_ready[1], o_r_valid[1], o_r_data[1], o_r_resp1,
                  o_aw_ready[1], o_w_ready[1], o_b_valid[1], o_b_resp1};
  wire all_out = m0_any | m1_any |
                 (|{s_ar_valid_o, s_ar_addr_o, s_r_ready_o, s_aw_valid_o, s_aw_addr_o,
                    s_w_valid_o, s_w_data_o, s_w_strb_o, s_b_ready_o, grant_o});

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Entered one cycle after AR was raised; leaves with the bus idle again.
  task automatic serve_read(input int m, input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] g;
    g = 2'b01 << m;
    chk("rd_grant", grant_o, g);
    chk("rd_s_ar_valid", s_ar_valid_o, 1);
    chk("rd_s_ar_addr", s_ar_addr_o, addr);
    chk("rd_s_aw_gated", s_aw_valid_o, 0);
    s_ar_ready_i = 1'b1;
    settle;
    chk("rd_m_ar_ready", o_ar_ready[m], 1);
    tick;
    ar_valid[m] = 1'b0; s_ar_ready_i = 1'b0;
    s_r_valid_i = 1'b1; s_r_data_i = data; s_r_resp_i = OKAY; r_ready[m] = 1'b1;
    settle;
    chk("rd_m_r_valid", o_r_valid[m], 1);
    chk("rd_m_r_data", o_r_data[m], data);
    chk("rd_other_r_valid", o_r_valid[1-m], 0);
    chk("rd_s_r_ready", s_r_ready_o, 1);
    tick;
    s_r_valid_i = 1'b0; s_r_data_i = '0; r_ready[m] = 1'b0;
    settle;
    chk("rd_idle_grant", grant_o, 0);
    chk("rd_idle_addr", s_ar_addr_o, 0);
  endtask

  task automatic serve_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input axi_resp_t resp);
    logic [1:0] g;
    g = 2'b01 << m;
    chk("wr_grant", grant_o, g);
    chk("wr_s_aw_valid", s_aw_valid_o, 1);
    chk("wr_s_aw_addr", s_aw_addr_o, addr);
    chk("wr_s_w_data", s_w_data_o, data);
    chk("wr_s_w_strb", s_w_strb_o, strb);
    chk("wr_s_ar_gated", s_ar_valid_o, 0);
    s_aw_ready_i = 1'b1; s_w_ready_i = 1'b1;
    settle;
    chk("wr_m_aw_ready", o_aw_ready[m], 1);
    chk("wr_m_w_ready", o_w_ready[m], 1);
    tick;
    aw_valid[m] = 1'b0; w_valid[m] = 1'b0; s_aw_ready_i = 1'b0; s_w_ready_i = 1'b0;
    s_b_valid_i = 1'b1; s_b_resp_i = resp; b_ready[m] = 1'b1;
    settle;
    chk("wr_m_b_valid", o_b_valid[m], 1);
    chk("wr_m_b_resp", o_b_resp_bits[m], resp);
    chk("wr_other_b_valid", o_b_valid[1-m], 0);
    tick;
    s_b_valid_i = 1'b0; s_b_resp_i = OKAY; b_ready[m] = 1'b0;
    settle;
    chk("wr_idle_grant", grant_o, 0);
  endtask

  task automatic req_write(input int m, input logic [31:0] addr, input logic [31:0] data);
    aw_valid[m] = 1'b1; aw_addr[m] = addr;
    w_valid[m] = 1'b1; w_data[m] = data; w_strb[m] = 4'hF;
  endtask

  initial begin
    ar_valid = '0; r_ready = '0; aw_valid = '0; w_valid = '0; b_ready = '0;
    ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
    s_ar_ready_i = 0; s_r_valid_i = 0; s_aw_ready_i = 0; s_w_ready_i = 0; s_b_valid_i = 0;
    s_r_data_i = '0; s_r_resp_i = OKAY; s_b_resp_i = OKAY;

    #2;
    chk("reset_outputs", all_out, 0);
    chk("reset_grant", grant_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // single read from IFU
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0000;
    settle;
    chk("t1_idle_cycle", s_ar_valid_o, 0);
    tick;
    serve_read(0, 32'h8000_0000, 32'hDEAD_BEEF);

    // single write from LSU: W accepted first, AW ready 3 cycles late
    req_write(1, 32'h8000_0100, 32'h1234_5678);
    tick;
    chk("t2_grant", grant_o, 2'b10);
    chk("t2_m0_quiet", m0_any, 0);
    chk("t2_s_aw_addr", s_aw_addr_o, 32'h8000_0100);
    chk("t2_s_w_data", s_w_data_o, 32'h1234_5678);
    chk("t2_s_w_strb", s_w_strb_o, 4'hF);
    s_w_ready_i = 1'b1;
    settle;
    chk("t2_w_ready", o_w_ready[1], 1);
    chk("t2_aw_wait", o_aw_ready[1], 0);
    tick;
    w_valid[1] = 1'b0; s_w_ready_i = 1'b0;
    repeat (2) begin
      settle;
      chk("t2_hold_grant", grant_o, 2'b10);
      chk("t2_m0_quiet", m0_any, 0);
      chk("t2_w_gone", s_w_valid_o, 0);
      tick;
    end
    s_aw_ready_i = 1'b1;
    settle;
    chk("t2_aw_ready", o_aw_ready[1], 1);
    tick;
    aw_valid[1] = 1'b0; s_aw_ready_i = 1'b0;
    s_b_valid_i = 1'b1; s_b_resp_i = OKAY; b_ready[1] = 1'b1;
    settle;
    chk("t2_b_valid", o_b_valid[1], 1);
    chk("t2_s_b_ready", s_b_ready_o, 1);
    chk("t2_m0_quiet", m0_any, 0);
    chk("t2_hold_grant", grant_o, 2'b10);
    tick;
    s_b_valid_i = 1'b0; b_ready[1] = 1'b0;
    settle;
    chk("t2_b_drop", o_b_valid[1], 0);
    chk("t2_idle", grant_o, 0);

    // tie: m0 AR vs m1 AW (last winner so far is m1)
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0200;
    req_write(1, 32'h8000_0300, 32'hCAFE_0001);
    tick;
`ifdef ARB_ROUND_ROBIN_EN
    serve_read(0, 32'h8000_0200, 32'h0000_1111);
    tick;
    serve_write(1, 32'h8000_0300, 32'hCAFE_0001, 4'hF, SLVERR);
`else
    serve_write(1, 32'h8000_0300, 32'hCAFE_0001, 4'hF, SLVERR);
    tick;
    serve_read(0, 32'h8000_0200, 32'h0000_1111);
`endif

    // lone IFU read, then a second tie which goes to the LSU in both modes
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0400;
    tick;
    serve_read(0, 32'h8000_0400, 32'h0000_2222);
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0500;
    req_write(1, 32'h8000_0600, 32'hCAFE_0002);
    tick;
    chk("tie2_grant", grant_o, 2'b10);
    serve_write(1, 32'h8000_0600, 32'hCAFE_0002, 4'hF, DECERR);
    tick;
    serve_read(0, 32'h8000_0500, 32'h0000_3333);

    // contention: m1 waits while m0's R is stalled 5 cycles
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0700;
    tick;
    chk("ct_grant_m0", grant_o, 2'b01);
    ar_valid[1] = 1'b1; ar_addr[1] = 32'h8000_0800; s_ar_ready_i = 1'b1;
    settle;
    chk("ct_m0_ar_ready", o_ar_ready[0], 1);
    chk("ct_m1_ar_ready", o_ar_ready[1], 0);
    tick;
    ar_valid[0] = 1'b0; r_ready[0] = 1'b1;
    repeat (5) begin
      settle;
      chk("ct_m1_ar_ready", o_ar_ready[1], 0);
      chk("ct_hold_grant", grant_o, 2'b01);
      tick;
    end
    s_ar_ready_i = 1'b0; s_r_valid_i = 1'b1; s_r_data_i = 32'h0000_4444;
    settle;
    chk("ct_r_valid", o_r_valid[0], 1);
    chk("ct_r_data", o_r_data[0], 32'h0000_4444);
    tick;
    s_r_valid_i = 1'b0; s_r_data_i = '0; r_ready[0] = 1'b0;
    settle;
    chk("ct_bubble", grant_o, 0);
    tick;
    serve_read(1, 32'h8000_0800, 32'h0000_5555);

    // m1 raises AR and AW together: read first, write on re-arbitration
    ar_valid[1] = 1'b1; ar_addr[1] = 32'h8000_0900;
    req_write(1, 32'h8000_0A00, 32'hCAFE_0003);
    tick;
    chk("both_aw_gated", s_aw_valid_o, 0);
    chk("both_aw_ready_gated", o_aw_ready[1], 0);
    serve_read(1, 32'h8000_0900, 32'h0000_6666);
    tick;
    chk("both_m0_idle", m0_any, 0);
    serve_write(1, 32'h8000_0A00, 32'hCAFE_0003, 4'hF, OKAY);

    // async reset in WR_M1 after the AW handshake
    req_write(1, 32'h8000_0B00, 32'hCAFE_0004);
    tick;
    s_aw_ready_i = 1'b1;
    settle;
    chk("rst_aw_ready", o_aw_ready[1], 1);
    tick;
    aw_valid[1] = 1'b0; s_aw_ready_i = 1'b0;
    settle;
    chk("rst_pre_grant", grant_o, 2'b10);
    chk("rst_pre_w_valid", s_w_valid_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_async_outputs", all_out, 0);
    chk("rst_async_grant", grant_o, 0);
    w_valid[1] = 1'b0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    ar_valid[0] = 1'b1; ar_addr[0] = 32'h8000_0C00;
    tick;
    serve_read(0, 32'h8000_0C00, 32'h0000_7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Two-master, one-slave AXI-Lite arbiter that lets the instruction fetch unit (master 0) and the load/store unit (master 1) share a single memory/SRAM slave port. It grants the slave to one master at a time and holds that grant for the whole transaction (AR→R or AW→W→B). It then releases the bus. It sits between the core's IFU/LSU master ports and the top-level memory interconnect, and supports exactly one outstanding transaction.

## Interface
Parameters:
- NUM_MST, 2, number of masters; fixed at 2 (index 0 = IFU, 1 = LSU).

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous, active-high reset
- m{0,1}_ar_valid_i / s_ar_valid_o  in/out  1  read address valid
- m{0,1}_ar_addr_i / s_ar_addr_o  in/out  `ysyx_23060251_axi_addr_bus`  read address
- s_ar_ready_i / m{0,1}_ar_ready_o  in/out  1  read address ready
- s_r_valid_i / m{0,1}_r_valid_o  in/out  1  read data valid
- s_r_data_i / m{0,1}_r_data_o  in/out  `ysyx_23060251_axi_data_bus`  read data
- s_r_resp_i / m{0,1}_r_resp_o  in/out  axi_resp_t  read response
- m{0,1}_r_ready_i / s_r_ready_o  in/out  1  read data ready
- m{0,1}_aw_valid_i / s_aw_valid_o  in/out  1  write address valid
- m{0,1}_aw_addr_i / s_aw_addr_o  in/out  `ysyx_23060251_axi_addr_bus`  write address
- s_aw_ready_i / m{0,1}_aw_ready_o  in/out  1  write address ready
- m{0,1}_w_valid_i / s_w_valid_o  in/out  1  write data valid
- m{0,1}_w_data_i / s_w_data_o  in/out  `ysyx_23060251_axi_data_bus`  write data
- m{0,1}_w_strb_i / s_w_strb_o  in/out  `ysyx_23060251_axi_strb_bus`  write strobe
- s_aw/w ready follow the same pattern: s_w_ready_i / m{0,1}_w_ready_o  in/out  1  write data ready
- s_b_valid_i / m{0,1}_b_valid_o  in/out  1  write response valid
- s_b_resp_i / m{0,1}_b_resp_o  in/out  axi_resp_t  write response
- m{0,1}_b_ready_i / s_b_ready_o  in/out  1  write response ready
- grant_o  output  2  one-hot current owner (00 = idle)

## Operation
- State is one-hot: IDLE, RD_M0, RD_M1, WR_M0, WR_M1.
- Request in IDLE: req[n] = mn_ar_valid_i | mn_aw_valid_i.
- Pick a winner in IDLE, then go to RD_Mn if mn_ar_valid_i, else to WR_Mn.
  - If a master raises AR and AW together, the read is served first; the write is arbitrated again after the read completes.
- In RD_Mn: the AR and R channels of master n are wired combinationally to the slave.
  - Exit to IDLE on R handshake (s_r_valid_i & s_r_ready_o).
- In WR_Mn: the AW, W and B channels of master n are wired to the slave.
  - AW and W pass independently, so either may come first.
  - Exit to IDLE on B handshake.
- The grant is held until completion even if the master drops valid. This is a protocol violation by the master; the arbiter takes no recovery action.
- All outputs to non-granted masters are 0: readies, valids, data, resp.
- Slave valid/ready outputs are 0 in IDLE.
- Slave address/data outputs are 0 when idle, so the bus does not carry stale addresses.
- The channel type not owned is gated: in RD_* the AW/W/B outputs are 0, and vice versa.
- Reset (asynchronous, any time, including mid-transaction):
  - state → IDLE and grant_o = 00, with every output 0 immediately.
  - last-grant register → 1.
  - An in-flight slave transaction is abandoned; the slave is reset by the same rst_i.

## Timing
- Request seen in IDLE at cycle t → state register updated at the t+1 edge.
- Granted valid appears on the slave at t+1.
- Ready/valid/data pass-through is combinational in both directions; the arbiter adds no pipeline stages.
- Completing handshake at cycle t → IDLE at t+1 → next grant at t+2 at the earliest.
  - Back-to-back transactions therefore have one idle bubble.
- A request that arrives while the bus is owned waits. Its valid must stay asserted (AXI rule) until its own grant.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: tie-break is round-robin.
  - On a simultaneous request, the master not granted last wins.
  - A 1-bit last-grant register updates on every grant.
  - Its reset value is 1, so the first tie goes to m0.
- Undefined: fixed priority, m1 (LSU) always wins a tie. The last-grant register is not synthesized.
- Single requests are unaffected in both modes.

## Structure
- Shared package axi_pkg:
  - axi_resp_t (OKAY/EXOKAY/SLVERR/DECERR).
  - Arbiter state localparams.
  - Master index constants MST_IFU=0, MST_LSU=1.
- One sub-module, arb_pick:
  - Inputs: 2-bit req and the last-grant bit.
  - Output: one-hot winner.
  - Purely combinational, with the round-robin/fixed mux under the macro.
- The top module holds the FSM and the channel muxes.

## Test plan
- Single read: m0 issues AR addr 0x8000_0000; the slave answers R data 0xDEAD_BEEF, resp OKAY.
  - Required: grant_o=01, s_ar_valid_o=1 at t+1, m0_r_data_o=0xDEAD_BEEF, m1_r_valid_o=0, IDLE one cycle after the R handshake.
- Single write: m1 writes 0x1234_5678 with strb 0xF to 0x8000_0100; the slave delays AW ready 3 cycles and accepts W first.
  - Required: grant_o=10 throughout; m1_b_valid_o mirrors the B handshake; no m0 outputs toggle.
- Tie: m0 AR and m1 AW both asserted in the same cycle.
  - Without the macro: m1 is granted first, then m0.
  - With ARB_ROUND_ROBIN_EN: m0 first (reset last-grant=1), then m1; a second tie then goes to m1.
- Contention: m1 requests while m0's read has its R stalled 5 cycles.
  - Required: m1_ar_ready_o stays 0.
  - m1 is granted exactly 2 cycles after m0's R handshake.
- AR+AW together from m1:
  - Required: the read completes first.
  - The write is granted on re-arbitration, with m0 idle.
- Reset mid-write: assert rst_i asynchronously while in WR_M1 after the AW handshake.
  - Required: all outputs 0 and grant_o=00 immediately, before the next clock edge.
  - After release, m0 can be granted normally.
